// File: rtl/judge_vote_n.sv
// Sequential N-voter judge: collects one yes/no vote per voter, closes on full turnout or timeout,
// and reports a registered verdict. Optional macro JUDGE_VETO_EN gives voter 0 a veto.
module judge_vote_n #(
    parameter int N_VOTERS = 3,
    parameter int CNT_W    = $clog2(N_VOTERS + 1),
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [N_VOTERS-1:0] vote_vld,
    input  logic [N_VOTERS-1:0] vote_val,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted,
    output logic                done,
    output logic                result,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic                timed_out
);

    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] MAJORITY = CNT_W'(N_VOTERS / 2 + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    thr_q;
    logic [TMR_W-1:0]    timer;
    logic [N_VOTERS-1:0] fresh, voted_nxt;
    logic [CNT_W-1:0]    yes_nxt;
    logic                all_in, expire, close, verdict;
`ifdef JUDGE_VETO_EN
    logic                v0_yes;
`endif

    // Votes arriving in the closing cycle must be visible to the verdict, so
    // everything below is computed from the post-update mask and count.
    always_comb begin
        fresh     = vote_vld & ~voted;
        voted_nxt = voted | fresh;
        yes_nxt   = yes_cnt;
        for (int i = 0; i < N_VOTERS; i++) begin
            yes_nxt = yes_nxt + CNT_W'(fresh[i] & vote_val[i]);
        end
        all_in  = &voted_nxt;
        expire  = (timer == TMR_LAST);
        close   = all_in || expire;
        verdict = (yes_nxt >= thr_q);
`ifdef JUDGE_VETO_EN
        verdict = verdict && voted_nxt[0] && (fresh[0] ? vote_val[0] : v0_yes);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COLLECT;
            S_COLLECT: if (close) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q     <= '0;
            timer     <= '0;
            voted     <= '0;
            yes_cnt   <= '0;
            result    <= 1'b0;
            timed_out <= 1'b0;
`ifdef JUDGE_VETO_EN
            v0_yes    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        thr_q     <= (threshold == '0) ? MAJORITY : threshold;
                        timer     <= '0;
                        voted     <= '0;
                        yes_cnt   <= '0;
                        result    <= 1'b0;
                        timed_out <= 1'b0;
`ifdef JUDGE_VETO_EN
                        v0_yes    <= 1'b0;
`endif
                    end
                end
                S_COLLECT: begin
                    voted   <= voted_nxt;
                    yes_cnt <= yes_nxt;
                    timer   <= timer + TMR_W'(1);
`ifdef JUDGE_VETO_EN
                    if (fresh[0]) v0_yes <= vote_val[0];
`endif
                    if (close) begin
                        timed_out <= !all_in;
                        result    <= verdict;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_judge_vote_n.sv
// Directed bench for judge_vote_n: a session-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_judge_vote_n;

    localparam int N  = 3;
    localparam int CW = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [CW-1:0] threshold;
    logic [N-1:0]  vote_vld, vote_val;
    logic          busy, done, result, timed_out;
    logic [N-1:0]  voted;
    logic [CW-1:0] yes_cnt;

    int checks = 0;
    int errors = 0;

    judge_vote_n #(.N_VOTERS(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .threshold(threshold),
        .vote_vld(vote_vld), .vote_val(vote_val), .busy(busy), .voted(voted),
        .done(done), .result(result), .yes_cnt(yes_cnt), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    // Session model: phase 0 idle, 1 collecting, 2 verdict cycle.
    int m_phase = 0, m_cyc = 0, m_thr = 0, m_yes = 0;
    bit m_hv[N], m_vv[N];
    bit m_to = 0, m_res = 0, m_all, m_armed = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_yes = 0; m_to = 0; m_res = 0; m_thr = 0; m_cyc = 0;
            for (int i = 0; i < N; i++) begin m_hv[i] = 0; m_vv[i] = 0; end
            m_armed = 1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_thr = (threshold == 0) ? (N / 2 + 1) : int'(threshold);
                    for (int i = 0; i < N; i++) begin m_hv[i] = 0; m_vv[i] = 0; end
                    m_cyc = 0; m_yes = 0; m_to = 0; m_res = 0; m_phase = 1;
                end
                1: begin
                    for (int i = 0; i < N; i++)
                        if (vote_vld[i] && !m_hv[i]) begin m_hv[i] = 1; m_vv[i] = vote_val[i]; end
                    m_yes = 0; m_all = 1;
                    for (int i = 0; i < N; i++) begin
                        if (m_hv[i] && m_vv[i]) m_yes++;
                        if (!m_hv[i]) m_all = 0;
                    end
                    if (m_all || m_cyc == TO - 1) begin
                        m_phase = 2;
                        m_to    = !m_all;
                        m_res   = (m_yes >= m_thr);
`ifdef JUDGE_VETO_EN
                        m_res   = m_res && m_hv[0] && m_vv[0];
`endif
                    end else begin
                        m_cyc++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_armed) begin
            logic [N-1:0] mask;
            for (int i = 0; i < N; i++) mask[i] = m_hv[i];
            chk("m_busy", busy, m_phase != 0);
            chk("m_done", done, m_phase == 2);
            chk("m_voted", voted, mask);
            chk("m_yes_cnt", yes_cnt, m_yes);
            chk("m_result", result, m_res);
            chk("m_timed_out", timed_out, m_to);
        end
    end

    // Inputs are applied here, take effect on the next rising edge, and the
    // task returns at the following falling edge so outputs can be read.
    task automatic step(input logic st, input logic [N-1:0] vl, input logic [N-1:0] vv);
        start = st; vote_vld = vl; vote_val = vv;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; threshold = '0; vote_vld = '0; vote_val = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_voted", voted, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_yes", yes_cnt, 0);
        chk("rst_to", timed_out, 0);
        rst = 1'b0;
        step(0, 3'b000, 3'b000);

        // All votes in first COLLECT cycle, majority threshold.
        threshold = 2'd0;
        step(1, 3'b000, 3'b000);
        chk("t1_busy", busy, 1);
        step(0, 3'b111, 3'b011);
        chk("t1_done", done, 1);
        chk("t1_yes", yes_cnt, 2);
        chk("t1_result", result, 1);
        chk("t1_to", timed_out, 0);
        step(0, 3'b000, 3'b000);
        chk("t1_done_low", done, 0);
        chk("t1_result_held", result, 1);

        // Spread votes with a repeat strobe from voter 2.
        step(1, 3'b000, 3'b000);
        step(0, 3'b100, 3'b100);
        chk("t2_voted_a", voted, 3'b100);
        step(0, 3'b001, 3'b000);
        step(0, 3'b100, 3'b000);
        chk("t2_voted_b", voted, 3'b101);
        chk("t2_yes_repeat", yes_cnt, 1);
        step(0, 3'b010, 3'b000);
        chk("t2_done", done, 1);
        chk("t2_voted", voted, 3'b111);
        chk("t2_yes", yes_cnt, 1);
        chk("t2_result", result, 0);
        step(0, 3'b000, 3'b000);

        // Timeout with voters missing, threshold 1.
        threshold = 2'd1;
        step(1, 3'b000, 3'b000);
        step(0, 3'b010, 3'b010);
        repeat (14) step(0, 3'b000, 3'b000);
        chk("t3_not_yet", done, 0);
        step(0, 3'b000, 3'b000);
        chk("t3_done", done, 1);
        chk("t3_to", timed_out, 1);
        chk("t3_yes", yes_cnt, 1);
        chk("t3_result", result, 1);
        step(0, 3'b000, 3'b000);

        // Start-cycle strobes ignored; last vote lands in the final timer cycle.
        threshold = 2'd0;
        step(1, 3'b111, 3'b111);
        step(0, 3'b011, 3'b011);
        chk("t4_voted_first", voted, 3'b011);
        repeat (14) step(0, 3'b000, 3'b000);
        step(0, 3'b100, 3'b100);
        chk("t4_done", done, 1);
        chk("t4_to", timed_out, 0);
        chk("t4_yes", yes_cnt, 3);
        chk("t4_result", result, 1);
        step(0, 3'b000, 3'b000);

        // Reset mid-session aborts without a verdict.
        step(1, 3'b000, 3'b000);
        step(0, 3'b001, 3'b001);
        rst = 1'b1;
        step(0, 3'b000, 3'b000);
        chk("t5_busy", busy, 0);
        chk("t5_voted", voted, 0);
        chk("t5_yes", yes_cnt, 0);
        chk("t5_result", result, 0);
        chk("t5_done", done, 0);
        rst = 1'b0;
        step(0, 3'b000, 3'b000);
        chk("t5_no_done", done, 0);

        // Voter 0 votes no with threshold 2.
        threshold = 2'd2;
        step(1, 3'b000, 3'b000);
        step(0, 3'b111, 3'b110);
        chk("t6_done", done, 1);
        chk("t6_yes", yes_cnt, 2);
`ifdef JUDGE_VETO_EN
        chk("t6_result_veto", result, 0);
`else
        chk("t6_result", result, 1);
`endif
        step(0, 3'b000, 3'b000);

        // Threshold equal to N requires unanimity.
        threshold = 2'd3;
        step(1, 3'b000, 3'b000);
        step(0, 3'b111, 3'b011);
        chk("t7_result", result, 0);
        step(0, 3'b000, 3'b000);
        step(1, 3'b000, 3'b000);
        step(0, 3'b111, 3'b111);
        chk("t7_result_all", result, 1);
        step(0, 3'b000, 3'b000);
        step(0, 3'b000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
